// File: rtl/graph_mem_loader_if.sv
// Byte-stream input and graph-memory write bus for graph_mem_loader.
// The slave modport is the loader side; the master modport is the producer/observer side.
interface graph_mem_loader_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 128
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] GMWAR;
  logic [DATA_W-1:0] GMWDR;
  logic              GMWE;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, GMWAR, GMWDR, GMWE
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, GMWAR, GMWDR, GMWE
  );
endinterface

// File: rtl/graph_mem_loader.sv
// Packs a byte stream into 128-bit words and writes them to graph memory from a base address.
// Optional feature macro GML_CHECKSUM_EN adds a 16-bit running byte checksum output.
module graph_mem_loader #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned LAST_ADDR = 8191
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  graph_mem_loader_if.slave bus,
  output logic              graph_ready,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
`ifdef GML_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned NumLanes = DATA_W / 8;
  localparam int unsigned IdxW     = $clog2(NumLanes);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic              gmwe_q, gmwe_d;
  logic [ADDR_W-1:0] gmwar_q, gmwar_d;
  logic [DATA_W-1:0] gmwdr_q, gmwdr_d;
  logic              graph_ready_q, graph_ready_d;
  logic              load_err_q, load_err_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
`ifdef GML_CHECKSUM_EN
  logic [15:0]       checksum_q, checksum_d;
`endif

  logic              accept;
  logic              close;
  logic [DATA_W-1:0] merged;

  assign accept = (state_q == StLoad) && bus.in_valid;
  assign close  = accept && ((idx_q == IdxW'(NumLanes - 1)) || bus.in_last);
  // Byte 0 lands in the most significant lane, matching hex-file word order.
  assign merged = pack_q | ({bus.in_data, {(DATA_W - 8){1'b0}}} >> (8 * idx_q));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    pack_d        = pack_q;
    gmwe_d        = 1'b0;
    gmwar_d       = gmwar_q;
    gmwdr_d       = gmwdr_q;
    graph_ready_d = graph_ready_q;
    load_err_d    = load_err_q;
    word_count_d  = word_count_q;
`ifdef GML_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d       = StLoad;
          addr_d        = base_addr;
          idx_d         = '0;
          pack_d        = '0;
          graph_ready_d = 1'b0;
          load_err_d    = 1'b0;
          word_count_d  = '0;
`ifdef GML_CHECKSUM_EN
          checksum_d    = '0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
`ifdef GML_CHECKSUM_EN
          checksum_d = checksum_q + {8'h00, bus.in_data};
`endif
          if (close) begin
            gmwe_d       = 1'b1;
            gmwar_d      = addr_q;
            gmwdr_d      = merged;
            word_count_d = word_count_q + 1'b1;
            idx_d        = '0;
            pack_d       = '0;
            if (bus.in_last) begin
              state_d       = StDone;
              graph_ready_d = 1'b1;
            end else if (addr_q == ADDR_W'(LAST_ADDR)) begin
              // Top of memory reached with more data pending: stop rather than wrap.
              state_d    = StErr;
              load_err_d = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            pack_d = merged;
            idx_d  = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      idx_q         <= '0;
      pack_q        <= '0;
      gmwe_q        <= 1'b0;
      gmwar_q       <= '0;
      gmwdr_q       <= '0;
      graph_ready_q <= 1'b0;
      load_err_q    <= 1'b0;
      word_count_q  <= '0;
`ifdef GML_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      pack_q        <= pack_d;
      gmwe_q        <= gmwe_d;
      gmwar_q       <= gmwar_d;
      gmwdr_q       <= gmwdr_d;
      graph_ready_q <= graph_ready_d;
      load_err_q    <= load_err_d;
      word_count_q  <= word_count_d;
`ifdef GML_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == StLoad);
  assign bus.GMWE     = gmwe_q;
  assign bus.GMWAR    = gmwar_q;
  assign bus.GMWDR    = gmwdr_q;
  assign graph_ready  = graph_ready_q;
  assign load_err     = load_err_q;
  assign word_count   = word_count_q;
`ifdef GML_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule
